rc4_ksa_ctrl: RTL and testbench
===============================

RC4_KSA_CTRL -- requirements
Module: rc4_ksa_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: begin key scheduling when sampled high in IDLE.
REQ-004 SHALL have port key_len, input, 4 bits: key length minus one (1..16 bytes), sampled with start.
REQ-005 SHALL have port key_addr, output, 4 bits: index of the key byte currently used.
REQ-006 SHALL have port key_byte, input, 8 bits: key byte at key_addr, valid in the same cycle (combinational source).
REQ-007 SHALL have port s_addr, output, 8 bits: S-box RAM address.
REQ-008 SHALL have port s_we, output, 1 bit: S-box RAM write enable.
REQ-009 SHALL have port s_wdata, output, 8 bits: S-box RAM write data.
REQ-010 SHALL have port s_rdata, input, 8 bits: S-box RAM read data, one cycle after s_addr with s_we low.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-013 SHALL have port j_out, output, 8 bits: current j register, for debug.

Function
REQ-014 SHALL implement the states IDLE, INIT, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J and DONE, held in registers i[7:0], j[7:0], k[3:0], si[7:0], sj[7:0] and klen[3:0].
REQ-015 SHALL, in IDLE with start=1, load klen=key_len, i=0, j=0 and k=0, then go to INIT; start SHALL be ignored in every other state.
REQ-016 SHALL, in INIT, drive s_we=1, s_addr=i and s_wdata=i, increment i each cycle, and after the i=255 write go to RD_I with i wrapped to 0 (256 cycles total).
REQ-017 SHALL, in RD_I, drive s_addr=i with s_we=0, then go to LD_I.
REQ-018 SHALL, in LD_I, latch si=s_rdata and update j <= j + s_rdata + key_byte (mod 256, carries discarded) with key_addr=k, then go to RD_J.
REQ-019 SHALL, in RD_J, drive s_addr=j (the updated value) with s_we=0, then go to LD_J.
REQ-020 SHALL, in LD_J, latch sj=s_rdata, then go to WR_I.
REQ-021 SHALL, in WR_I, write S[i]=sj, then go to WR_J.
REQ-022 SHALL, in WR_J, write S[j]=si; if i=255 it SHALL go to DONE, otherwise it SHALL increment i, set k=0 when k=klen (else k+1), and go to RD_I.
REQ-023 SHALL handle i=j correctly: both writes of the pair store the same value and leave the entry unchanged.
REQ-024 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 SHALL, with start sampled in cycle t, run INIT in cycles t+1..t+256, the swap loop (6 cycles per i) in t+257..t+1792, and DONE in t+1793.
REQ-026 SHALL drive s_we=0 in all states other than INIT, WR_I and WR_J.
REQ-027 SHALL drive key_addr=k at all times.

Reset
REQ-028 SHALL, on rst_n low at a clock edge, force state=IDLE and i=j=k=si=sj=klen=0, giving busy=0, done=0, s_we=0, s_addr=0, s_wdata=0, key_addr=0 and j_out=0.
REQ-029 SHALL let reset asserted mid-operation abandon the run immediately, with no further RAM writes and no done pulse.

Configuration
REQ-030 SHALL support macro RC4_KSA_ABORT_EN: when defined, add input abort (1 bit); abort=1 in any non-IDLE state SHALL return to IDLE next cycle with no write that cycle and no done pulse, and register values other than state are don't-care. When undefined, there SHALL be no abort port and no abort logic.

Verification
REQ-031 SHALL cover: reset, then idle -> busy=0, done=0 and s_we=0 for 10 cycles.
REQ-032 SHALL cover: start at t, key_len=0, key_byte=0x00 -> cycles t+1..t+256 write S[n]=n; iteration i=2 gives j=0x03 and writes S[2]=0x03 then S[3]=0x02.
REQ-033 SHALL cover: key_len=2, key bytes 0x4B,0x65,0x79 -> key_addr sequence 0,1,2,0,...; the final RAM equals a software KSA model for key "Key"; done pulses at exactly t+1793.
REQ-034 SHALL cover: start pulsed again while busy -> no restart and done timing unchanged.
REQ-035 SHALL cover: rst_n driven low at cycle t+700 -> IDLE next cycle, no write after reset, and no done.
REQ-036 SHALL cover (with RC4_KSA_ABORT_EN): abort at cycle t+300 -> IDLE next cycle, no write that cycle, no done, and a subsequent start runs a full 1793-cycle sequence.

Source files
------------

// File: rtl/rc4_ksa_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rc4_ksa_ctrl
// Brief   : RC4 key-scheduling controller driving an external 256x8 S-box RAM.
//           Optional abort input enabled by macro RC4_KSA_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rc4_ksa_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] key_len,
    output logic [3:0] key_addr,
    input  logic [7:0] key_byte,
    output logic [7:0] s_addr,
    output logic       s_we,
    output logic [7:0] s_wdata,
    input  logic [7:0] s_rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] j_out
`ifdef RC4_KSA_ABORT_EN
    ,
    input  logic       abort
`endif
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_INIT = 4'd1,
        ST_RD_I = 4'd2,
        ST_LD_I = 4'd3,
        ST_RD_J = 4'd4,
        ST_LD_J = 4'd5,
        ST_WR_I = 4'd6,
        ST_WR_J = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [3:0] r_k;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [3:0] r_klen;

    assign key_addr = r_k;
    assign j_out    = r_j;
    assign busy     = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        s_we        = 1'b0;
        s_addr      = 8'd0;
        s_wdata     = 8'd0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_INIT;
            ST_INIT: begin
                s_we    = 1'b1;
                s_addr  = r_i;
                s_wdata = r_i;
                if (r_i == 8'hFF) w_state_nxt = ST_RD_I;
            end
            ST_RD_I: begin
                s_addr      = r_i;
                w_state_nxt = ST_LD_I;
            end
            ST_LD_I: w_state_nxt = ST_RD_J;
            ST_RD_J: begin
                s_addr      = r_j;
                w_state_nxt = ST_LD_J;
            end
            ST_LD_J: w_state_nxt = ST_WR_I;
            ST_WR_I: begin
                s_we        = 1'b1;
                s_addr      = r_i;
                s_wdata     = r_sj;
                w_state_nxt = ST_WR_J;
            end
            ST_WR_J: begin
                s_we        = 1'b1;
                s_addr      = r_j;
                s_wdata     = r_si;
                w_state_nxt = (r_i == 8'hFF) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
`ifdef RC4_KSA_ABORT_EN
        // Abort wins over everything: suppress this cycle's write and pulse.
        if (abort && (r_state != ST_IDLE)) begin
            s_we        = 1'b0;
            done        = 1'b0;
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 4'd0;
            r_si    <= 8'd0;
            r_sj    <= 8'd0;
            r_klen  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_klen <= key_len;
                        r_i    <= 8'd0;
                        r_j    <= 8'd0;
                        r_k    <= 4'd0;
                    end
                end
                ST_INIT: r_i <= r_i + 8'd1;
                ST_LD_I: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata + key_byte;
                end
                ST_LD_J: r_sj <= s_rdata;
                ST_WR_J: begin
                    if (r_i != 8'hFF) begin
                        r_i <= r_i + 8'd1;
                        r_k <= (r_k == r_klen) ? 4'd0 : r_k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc4_ksa_ctrl
// Brief   : Self-checking bench for rc4_ksa_ctrl against a software KSA model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rc4_ksa_ctrl;

    localparam int LOGN = 32768;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] key_len;
    logic [3:0] key_addr;
    logic [7:0] key_byte;
    logic [7:0] s_addr;
    logic       s_we;
    logic [7:0] s_wdata;
    logic [7:0] s_rdata;
    logic       busy;
    logic       done;
    logic [7:0] j_out;
`ifdef RC4_KSA_ABORT_EN
    logic       abort;
`endif

    always #5 clk = ~clk;

    rc4_ksa_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key_addr (key_addr),
        .key_byte (key_byte),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .busy     (busy),
        .done     (done),
        .j_out    (j_out)
`ifdef RC4_KSA_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    // Key ROM (combinational) and S-box RAM (registered read).
    logic [7:0] key_mem [16];
    logic [7:0] mem [256];
    assign key_byte = key_mem[key_addr];

    always @(posedge clk) begin
        if (s_we) mem[s_addr] <= s_wdata;
        s_rdata <= mem[s_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    int         dq[$];
    logic [7:0] jlog  [LOGN];
    logic [3:0] kalog [LOGN];
    logic       blog  [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            jlog[cyc]  <= j_out;
            kalog[cyc] <= key_addr;
            blog[cyc]  <= busy;
        end
        if (s_we) wq.push_back('{cyc, s_addr, s_wdata});
        if (done) dq.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected write trace (cycle offsets relative to start cycle), j/k per i, final S.
    int         exp_wc [768];
    logic [7:0] exp_wa [768];
    logic [7:0] exp_wd [768];
    logic [7:0] exp_j  [256];
    logic [3:0] exp_k  [256];
    logic [7:0] exp_s  [256];

    function automatic void build_model(input int len);
        int s[256];
        int jj;
        int kk;
        int tmp;
        for (int n = 0; n < 256; n++) begin
            s[n] = n;
            exp_wc[n] = 1 + n;
            exp_wa[n] = 8'(n);
            exp_wd[n] = 8'(n);
        end
        jj = 0;
        for (int i = 0; i < 256; i++) begin
            kk = i % (len + 1);
            jj = (jj + s[i] + int'(key_mem[kk])) % 256;
            exp_j[i] = 8'(jj);
            exp_k[i] = 4'(kk);
            exp_wc[256 + 2*i]     = 261 + 6*i;
            exp_wa[256 + 2*i]     = 8'(i);
            exp_wd[256 + 2*i]     = 8'(s[jj]);
            exp_wc[256 + 2*i + 1] = 262 + 6*i;
            exp_wa[256 + 2*i + 1] = 8'(jj);
            exp_wd[256 + 2*i + 1] = 8'(s[i]);
            tmp   = s[i];
            s[i]  = s[jj];
            s[jj] = tmp;
        end
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(s[n]);
    endfunction

    // Starts a run in cycle t, then drives per-cycle disturbances for ncyc cycles.
    task automatic run_ksa(input int len, input bit restart, input int rst_at,
                           input int abort_at, input int ncyc, output int t);
        wq.delete();
        dq.delete();
        build_model(len);
        @(posedge clk); #1;
        key_len = 4'(len);
        start   = 1'b1;
        t       = cyc;
        while (cyc < t + ncyc) begin
            @(posedge clk); #1;
            start   = restart && ((cyc == t + 500) || (cyc == t + 1200));
            key_len = 4'($urandom);
            rst_n   = !((rst_at >= 0) && (cyc >= t + rst_at) && (cyc < t + rst_at + 3));
`ifdef RC4_KSA_ABORT_EN
            abort   = (abort_at >= 0) && (cyc == t + abort_at);
`endif
        end
        start = 1'b0;
        rst_n = 1'b1;
`ifdef RC4_KSA_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, s_we, s_addr, s_wdata, key_addr, j_out} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b addr=%h wdata=%h kaddr=%h j=%h, required all 0",
                     busy, done, s_we, s_addr, s_wdata, key_addr, j_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, s_we} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: busy=%b done=%b we=%b, required 0 0 0", c, busy, done, s_we);
            end
        end
    endtask

    task automatic test_identity_key();
        int t;
        bit bad;
        for (int n = 0; n < 16; n++) key_mem[n] = 8'h00;
        run_ksa(0, 1'b0, -1, -1, 1800, t);
        n_checks++;
        if (wq.size() != 768) begin
            n_fail++;
            $display("FAIL id_write_count: got %0d, required 768", wq.size());
        end
        bad = 1'b0;
        for (int n = 0; n < 256 && n < wq.size(); n++)
            if (wq[n].c != t + 1 + n || wq[n].a != 8'(n) || wq[n].d != 8'(n)) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL id_init_writes: S[n]=n at t+1+n not observed (first c=%0d a=%h d=%h)",
                     wq[0].c - t, wq[0].a, wq[0].d);
        end
        if (wq.size() >= 262) begin
            n_checks++;
            if (wq[260].c != t + 273 || wq[260].a != 8'h02 || wq[260].d != 8'h03 ||
                wq[261].c != t + 274 || wq[261].a != 8'h03 || wq[261].d != 8'h02) begin
                n_fail++;
                $display("FAIL id_iter2_swap: got (t+%0d S[%h]=%h)(t+%0d S[%h]=%h), required (t+273 S[02]=03)(t+274 S[03]=02)",
                         wq[260].c - t, wq[260].a, wq[260].d, wq[261].c - t, wq[261].a, wq[261].d);
            end
        end
        n_checks++;
        if (jlog[t + 259 + 12] !== 8'h03) begin
            n_fail++;
            $display("FAIL id_iter2_j: j_out=%h, required 03", jlog[t + 259 + 12]);
        end
        bad = 1'b0;
        for (int n = 0; n < 768 && n < wq.size(); n++)
            if (wq[n].c != t + exp_wc[n] || wq[n].a != exp_wa[n] || wq[n].d != exp_wd[n]) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL id_write_trace: write trace differs from KSA model");
        end
    endtask

    task automatic test_key_word();
        int t;
        int nbad;
        key_mem[0] = 8'h4B;
        key_mem[1] = 8'h65;
        key_mem[2] = 8'h79;
        run_ksa(2, 1'b0, -1, -1, 1800, t);
        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (kalog[t + 258 + 6*i] !== exp_k[i]) nbad++;
        n_checks++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL key_addr_seq: %0d iterations wrong (i=3 got %0d), required %0d", nbad,
                     kalog[t + 258 + 18], exp_k[3]);
        end
        nbad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) nbad++;
        n_checks++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL key_final_ram: %0d entries differ, S[0] got %h required %h", nbad, mem[0], exp_s[0]);
        end
        n_checks++;
        if (dq.size() != 1 || dq[0] != t + 1793) begin
            n_fail++;
            $display("FAIL key_done_time: pulses=%0d first at t+%0d, required 1 at t+1793",
                     dq.size(), (dq.size() > 0) ? dq[0] - t : -1);
        end
        n_checks++;
        if ({blog[t], blog[t + 1], blog[t + 1793], blog[t + 1794]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL key_busy_window: busy t,t+1,t+1793,t+1794 = %b%b%b%b, required 0110",
                     blog[t], blog[t + 1], blog[t + 1793], blog[t + 1794]);
        end
    endtask

    task automatic test_random_keys();
        int t;
        int len;
        int nbad;
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(0, 15);
            for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom);
            run_ksa(len, 1'b0, -1, -1, 1800, t);
            nbad = 0;
            for (int i = 0; i < 256; i++) if (jlog[t + 259 + 6*i] !== exp_j[i]) nbad++;
            n_checks++;
            if (nbad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_j_seq: %0d j values wrong (len=%0d)", r, nbad, len + 1);
            end
            nbad = 0;
            for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) nbad++;
            n_checks++;
            if (nbad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_final_ram: %0d entries differ (len=%0d)", r, nbad, len + 1);
            end
            n_checks++;
            if (dq.size() != 1 || dq[0] != t + 1793) begin
                n_fail++;
                $display("FAIL rand%0d_done: pulses=%0d, required 1 at t+1793", r, dq.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int nbad;
        for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom);
        run_ksa(5, 1'b1, -1, -1, 1800, t);
        n_checks++;
        if (dq.size() != 1 || dq[0] != t + 1793 || wq.size() != 768) begin
            n_fail++;
            $display("FAIL restart_ignored: pulses=%0d writes=%0d, required 1 pulse at t+1793 and 768 writes",
                     dq.size(), wq.size());
        end
        nbad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) nbad++;
        n_checks++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL restart_final_ram: %0d entries differ, required 0", nbad);
        end
    endtask

    task automatic test_reset_mid_run();
        int t;
        int last;
        for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom);
        run_ksa(3, 1'b0, 700, -1, 760, t);
        last = (wq.size() > 0) ? wq[wq.size() - 1].c - t : -1;
        n_checks++;
        if (wq.size() != 404 || last > 700) begin
            n_fail++;
            $display("FAIL rst_mid_writes: writes=%0d last at t+%0d, required 404 with last at t+700", wq.size(), last);
        end
        n_checks++;
        if (blog[t + 701] !== 1'b0 || jlog[t + 701] !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_idle: busy=%b j=%h at t+701, required 0 and 00", blog[t + 701], jlog[t + 701]);
        end
        n_checks++;
        if (dq.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: pulses=%0d, required 0", dq.size());
        end
    endtask

`ifdef RC4_KSA_ABORT_EN
    task automatic test_abort();
        int t;
        int nbad;
        for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom);
        run_ksa(1, 1'b0, -1, 300, 320, t);
        n_checks++;
        if (blog[t + 301] !== 1'b0 || dq.size() != 0 || wq.size() != 270) begin
            n_fail++;
            $display("FAIL abort300: busy@t+301=%b pulses=%0d writes=%0d, required 0 0 270",
                     blog[t + 301], dq.size(), wq.size());
        end
        run_ksa(1, 1'b0, -1, 321, 340, t);
        n_checks++;
        if (blog[t + 322] !== 1'b0 || dq.size() != 0 || wq.size() != 276) begin
            n_fail++;
            $display("FAIL abort_on_write: busy@t+322=%b pulses=%0d writes=%0d, required 0 0 276",
                     blog[t + 322], dq.size(), wq.size());
        end
        run_ksa(1, 1'b0, -1, -1, 1800, t);
        nbad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) nbad++;
        n_checks++;
        if (dq.size() != 1 || dq[0] != t + 1793 || nbad != 0) begin
            n_fail++;
            $display("FAIL abort_rerun: pulses=%0d ram_diffs=%0d, required 1 at t+1793 and 0", dq.size(), nbad);
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key_len = 4'd0;
`ifdef RC4_KSA_ABORT_EN
        abort   = 1'b0;
`endif
        for (int n = 0; n < 16; n++) key_mem[n] = 8'h00;
        test_reset();
        test_identity_key();
        test_key_word();
        test_random_keys();
        test_back_to_back();
        test_reset_mid_run();
`ifdef RC4_KSA_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
